// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational instruction
// port and buffers {pc, insn} pairs in a small in-order FIFO toward decode.
module fetch_stage #(
  parameter int unsigned         AWIDTH     = 32,
  parameter int unsigned         DWIDTH     = 32,
  parameter logic [AWIDTH-1:0]   BASE_ADDR  = 32'h01000000,
  parameter int unsigned         FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en_i,
  output logic [AWIDTH-1:0] mem_pc_o,
  output logic              mem_read_en_o,
  input  logic [DWIDTH-1:0] mem_insn_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [AWIDTH-1:0] dec_pc_o,
  output logic [DWIDTH-1:0] dec_insn_o,
  output logic [31:0]       fetch_count_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [AWIDTH-1:0] pc_reg;
  logic [CW-1:0]     count_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [31:0]       fetch_count_reg;

  logic [AWIDTH-1:0] pc_mem   [FIFO_DEPTH];
  logic [DWIDTH-1:0] insn_mem [FIFO_DEPTH];

  logic pop;
  logic space;
  logic fetch;
  logic empty;

  assign empty = (count_reg == '0);
  assign pop   = ~empty & dec_ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign space = (count_reg < CW'(FIFO_DEPTH)) | pop;
  assign fetch = rst & fetch_en_i & ~redirect_i & space;

  assign mem_pc_o      = pc_reg;
  assign mem_read_en_o = fetch;
  assign fetch_count_o = fetch_count_reg;

  assign dec_valid_o = ~empty;
  assign dec_pc_o    = empty ? '0 : pc_mem[rd_ptr_reg];
  assign dec_insn_o  = empty ? '0 : insn_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (fetch) begin
      pc_mem[wr_ptr_reg]   <= pc_reg;
      insn_mem[wr_ptr_reg] <= mem_insn_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg          <= BASE_ADDR;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fetch_count_reg <= '0;
    end else if (redirect_i) begin
      // Flush drops any concurrent pop; the fetch counter survives.
      pc_reg     <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (fetch) begin
        pc_reg          <= pc_reg + AWIDTH'(4);
        wr_ptr_reg      <= wr_ptr_reg + PW'(1);
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + CW'(fetch) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory word at address BASE+4*i is 0x13+i.
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'h01000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en_i = 1'b1;
  logic [31:0] mem_pc_o;
  logic        mem_read_en_o;
  logic [31:0] mem_insn_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b1;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_insn_o;
  logic [31:0] fetch_count_o;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  assign mem_insn_i = 32'h00000013 + ((mem_pc_o - BASE) >> 2);

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en_i    (fetch_en_i),
    .mem_pc_o      (mem_pc_o),
    .mem_read_en_o (mem_read_en_o),
    .mem_insn_i    (mem_insn_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_pc_o      (dec_pc_o),
    .dec_insn_o    (dec_insn_o),
    .fetch_count_o (fetch_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  initial begin
    // Reset held for three cycles
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(dec_valid_o), 32'd0);
    chk("rst_rden", 32'(mem_read_en_o), 32'd0);
    chk("rst_mempc", mem_pc_o, BASE);
    chk("rst_fcnt", fetch_count_o, 32'd0);
    chk("rst_decpc", dec_pc_o, 32'd0);
    chk("rst_insn", dec_insn_o, 32'd0);
    rst = 1'b1;

    // Streaming at one instruction per cycle
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("strm_valid", 32'(dec_valid_o), 32'd1);
      chk("strm_pc", dec_pc_o, BASE + 32'(4 * k));
      chk("strm_insn", dec_insn_o, 32'h13 + 32'(k));
      chk("strm_fcnt", fetch_count_o, 32'(k + 1));
    end

    // Backpressure from reset release
    rst = 1'b0;
    dec_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_rden", 32'(mem_read_en_o), 32'd0);
    chk("bp_mempc", mem_pc_o, BASE + 32'd8);
    chk("bp_fcnt", fetch_count_o, 32'd2);
    chk("bp_head", dec_pc_o, BASE);
    dec_ready_i = 1'b1;
    #1 chk("bp_pop_rden", 32'(mem_read_en_o), 32'd1);
    @(negedge clk);
    dec_ready_i = 1'b0;
    #1;
    chk("bp_full_rden", 32'(mem_read_en_o), 32'd0);
    chk("bp_head2", dec_pc_o, BASE + 32'd4);
    chk("bp_fcnt2", fetch_count_o, 32'd3);

    // Redirect while full
    redirect_i = 1'b1;
    redirect_pc_i = 32'h01000103;
    #1 chk("rd_rden", 32'(mem_read_en_o), 32'd0);
    @(negedge clk);
    redirect_i = 1'b0;
    chk("rd_valid", 32'(dec_valid_o), 32'd0);
    chk("rd_decpc", dec_pc_o, 32'd0);
    chk("rd_mempc", mem_pc_o, 32'h01000100);
    chk("rd_fcnt", fetch_count_o, 32'd3);
    @(negedge clk);
    chk("rd_head", dec_pc_o, 32'h01000100);
    chk("rd_insn", dec_insn_o, 32'h00000053);
    chk("rd_fcnt2", fetch_count_o, 32'd4);

    // Redirect colliding with a pop at count=1
    redirect_i = 1'b1;
    redirect_pc_i = 32'h01000200;
    dec_ready_i = 1'b1;
    @(negedge clk);
    redirect_i = 1'b0;
    dec_ready_i = 1'b0;
    chk("rc_valid", 32'(dec_valid_o), 32'd0);
    chk("rc_insn", dec_insn_o, 32'd0);
    chk("rc_mempc", mem_pc_o, 32'h01000200);
    @(negedge clk);
    chk("rc_head", dec_pc_o, 32'h01000200);
    chk("rc_hinsn", dec_insn_o, 32'h00000093);
    chk("rc_fcnt", fetch_count_o, 32'd5);

    // Fetch disable mid-stream drains the FIFO and freezes the PC
    dec_ready_i = 1'b1;
    @(negedge clk);
    chk("fe_head", dec_pc_o, 32'h01000204);
    fetch_en_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fe_valid", 32'(dec_valid_o), 32'd0);
      chk("fe_mempc", mem_pc_o, 32'h01000208);
      chk("fe_fcnt", fetch_count_o, 32'd6);
    end
    fetch_en_i = 1'b1;
    #1 chk("fe_rden", 32'(mem_read_en_o), 32'd1);
    @(negedge clk);
    chk("fe_resume", dec_pc_o, 32'h01000208);
    chk("fe_rinsn", dec_insn_o, 32'h00000095);
    chk("fe_rfcnt", fetch_count_o, 32'd7);

    // Asynchronous reset between edges
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 32'(dec_valid_o), 32'd0);
    chk("ar_mempc", mem_pc_o, BASE);
    chk("ar_fcnt", fetch_count_o, 32'd0);
    chk("ar_rden", 32'(mem_read_en_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_head", dec_pc_o, BASE);
    chk("ar_insn", dec_insn_o, 32'h00000013);
    chk("ar_fcnt2", fetch_count_o, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage sitting directly upstream of the unified byte-addressable memory's instruction port and downstream-feeding decode. Owns the program counter and drives the memory fetch address and read enable. Captures the combinationally returned instruction into a small in-order FIFO that has a valid/ready handshake toward decode. Supports pipeline redirect (branch/jump) with flush.

Parameters:
AWIDTH, 32, address width of PC and memory fetch address
DWIDTH, 32, instruction width
BASE_ADDR, 32'h01000000, PC reset value (start of memory)
FIFO_DEPTH, 2, fetch-buffer entries (power of two, >=2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
fetch_en_i  input  1  global fetch enable; 0 = hold PC, issue no fetch
mem_pc_o  output  AWIDTH  fetch address to memory instruction port
mem_read_en_o  output  1  memory instruction read enable
mem_insn_i  input  DWIDTH  instruction returned combinationally for mem_pc_o in the same cycle
redirect_i  input  1  redirect request from execute (taken branch/jump)
redirect_pc_i  input  AWIDTH  redirect target
dec_valid_o  output  1  FIFO head valid toward decode
dec_ready_i  input  1  decode accepts head this cycle
dec_pc_o  output  AWIDTH  PC of head entry
dec_insn_o  output  DWIDTH  instruction of head entry
fetch_count_o  output  32  number of instructions pushed since reset

Behaviour:
- Reset (rst=0, asynchronous): pc=BASE_ADDR, FIFO count=0, rd/wr pointers=0, fetch_count_o=0. Outputs: dec_valid_o=0, dec_pc_o=0, dec_insn_o=0, mem_read_en_o=0, mem_pc_o=BASE_ADDR.
- mem_pc_o = pc at all times.
- pop = dec_valid_o & dec_ready_i.
- space = (count < FIFO_DEPTH) | pop. Popping while full frees a slot in the same cycle.
- fetch = rst & fetch_en_i & ~redirect_i & space. mem_read_en_o = fetch (combinational).
- On posedge with fetch=1: push {pc, mem_insn_i} at wr pointer, pc <= pc + 4 (wraps modulo 2^AWIDTH, no overflow flag), fetch_count_o += 1 (wraps at 2^32).
- On posedge with pop=1 and redirect_i=0: advance rd pointer.
- count' = count + push - pop. Simultaneous push and pop leaves count unchanged, including when full or when count=1.
- Empty FIFO: dec_valid_o=0; dec_pc_o and dec_insn_o are driven to 0, not stale data. Non-empty: head entry presented, held stable until popped.
- Redirect (redirect_i=1), highest priority:
  - no push that cycle; any pop that cycle is discarded;
  - count <= 0 and pointers reset;
  - pc <= {redirect_pc_i[AWIDTH-1:2], 2'b00} (low two bits forced to zero);
  - fetch_count_o is not cleared.
  - The first fetch from the target occurs the following cycle, provided fetch_en_i=1.
- fetch_en_i=0: PC holds, no push. Pops continue normally.
- Latency: an instruction fetched in cycle N is visible on dec_* in cycle N+1 (registered FIFO). Throughput is 1 instr/cycle with dec_ready_i=1.
- mem_insn_i is stored verbatim. Out-of-range fill values from memory (e.g. 32'hDEAD_BEEF) pass through unchecked.
- Reset asserted mid-operation clears all state immediately, independent of clk. Fetching resumes at BASE_ADDR on the first posedge after release.

Test Plan:
- Reset/stream: hold rst=0 for 3 cycles, then release with fetch_en_i=1, dec_ready_i=1 and memory word i = 32'h00000013+i. Required: dec_valid_o=0 during reset. From cycle 1 after release, dec_pc_o = 32'h01000000, 04, 08... with the matching insn each cycle, and fetch_count_o incrementing by 1 per cycle.
- Backpressure: dec_ready_i=0 from release. Required: exactly 2 pushes (PC 0x01000000, 0x01000004), then mem_read_en_o=0 and PC holds at 0x01000008. Raise dec_ready_i for one cycle: one pop and one push in the same cycle, count stays 2, and the head becomes 0x01000004.
- Redirect flush: while the FIFO is full, pulse redirect_i with redirect_pc_i=32'h01000103. Required: next cycle dec_valid_o=0 and PC=0x01000100. The cycle after, the head is PC 0x01000100.
- Redirect + pop collision: redirect_i=1 and dec_ready_i=1 in the same cycle with count=1. Required: the FIFO is empty afterward, with no double-pop and no stale entry.
- fetch_en_i=0 for 4 cycles mid-stream with ready=1. Required: the FIFO drains to empty, PC is frozen, and fetch_count_o is unchanged. Re-enable: fetching resumes at the frozen PC.
- Async reset mid-stream: drop rst between clock edges. Required: dec_valid_o=0, mem_pc_o=0x01000000 and fetch_count_o=0 immediately, before the next posedge.
